// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Request fields are held stable from dReq until the single-cycle dAck.
interface mem_access_stage_if;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dBe;
    logic [31:0] dRdata;
    logic        dAck;

    modport master (
        output dReq, dWe, dAddr, dWdata, dBe,
        input  dRdata, dAck
    );

    modport slave (
        input  dReq, dWe, dAddr, dWdata, dBe,
        output dRdata, dAck
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues handshaked loads/stores, extends load data, stalls while busy.
// Optional `MEM_PERF_CNT_EN adds load/store/stall event counters.
module mem_access_stage #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRdm,
    input  logic        memWrtm,
    input  logic [2:0]  funct3m,
    input  logic [31:0] aluRsltm,
    input  logic [31:0] wrtDatam,
    output logic [31:0] readDm,
    output logic        memStallm,
    output logic        misAlgnm,
    output logic        busErrm,
`ifdef MEM_PERF_CNT_EN
    output logic [31:0] ldCnt,
    output logic [31:0] stCnt,
    output logic [31:0] stallCnt,
`endif
    mem_access_stage_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] readdm_q, readdm_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;

    logic        access, is_store, f3_legal, aligned;
    logic [1:0]  sz;
    logic        req, we_o, stall, misalgn, buserr;
    logic [31:0] addr_o, wdata_o;
    logic [3:0]  be_o;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   lane_wdata = {4{wd[7:0]}};
            2'b01:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    // The byte/half is picked from the latched offset; bit 2 of funct3 selects zero-extension.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0]       sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = rd >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'h0, b};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = rd;
        endcase
    endfunction

    always_comb begin
        access   = memRdm | memWrtm;
        is_store = memWrtm;
        sz       = funct3m[1:0];
        if (is_store) begin
            f3_legal = (funct3m == 3'b000) || (funct3m == 3'b001) || (funct3m == 3'b010);
        end else begin
            f3_legal = (funct3m == 3'b000) || (funct3m == 3'b001) || (funct3m == 3'b010) ||
                       (funct3m == 3'b100) || (funct3m == 3'b101);
        end
        case (sz)
            2'b01:   aligned = ~aluRsltm[0];
            2'b10:   aligned = (aluRsltm[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        readdm_d = readdm_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        req      = 1'b0;
        we_o     = 1'b0;
        addr_o   = 32'h0;
        wdata_o  = 32'h0;
        be_o     = 4'h0;
        stall    = 1'b0;
        misalgn  = 1'b0;
        buserr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (f3_legal && aligned) begin
                        req      = 1'b1;
                        stall    = 1'b1;
                        we_o     = is_store;
                        addr_o   = {aluRsltm[31:2], 2'b00};
                        wdata_o  = lane_wdata(sz, wrtDatam);
                        be_o     = lane_be(sz, aluRsltm[1:0]);
                        addr_d   = aluRsltm;
                        we_d     = is_store;
                        be_d     = be_o;
                        wdata_d  = wdata_o;
                        funct3_d = funct3m;
                        cnt_d    = 8'h0;
                        state_d  = BUSY;
                    end else begin
                        misalgn  = 1'b1;
                        readdm_d = 32'h0;
                    end
                end
            end
            BUSY: begin
                req     = 1'b1;
                stall   = 1'b1;
                we_o    = we_q;
                addr_o  = {addr_q[31:2], 2'b00};
                wdata_o = wdata_q;
                be_o    = be_q;
                if (bus.dAck) begin
                    if (!we_q) begin
                        readdm_d = load_ext(funct3_q, addr_q[1:0], bus.dRdata);
                    end
                    cnt_d   = 8'h0;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    buserr   = 1'b1;
                    readdm_d = 32'h0;
                    cnt_d    = 8'h0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'h0;
            readdm_q <= 32'h0;
            addr_q   <= 32'h0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            readdm_q <= readdm_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
        end
    end

    // Outputs are forced low while reset is held so an abandoned request never leaks out.
    assign bus.dReq    = req & ~rst;
    assign bus.dWe     = we_o & ~rst;
    assign bus.dAddr   = rst ? 32'h0 : addr_o;
    assign bus.dWdata  = rst ? 32'h0 : wdata_o;
    assign bus.dBe     = rst ? 4'h0 : be_o;
    assign memStallm   = stall & ~rst;
    assign misAlgnm    = misalgn & ~rst;
    assign busErrm     = buserr & ~rst;
    assign readDm      = readdm_q;

`ifdef MEM_PERF_CNT_EN
    logic [31:0] ldcnt_q, ldcnt_d;
    logic [31:0] stcnt_q, stcnt_d;
    logic [31:0] stallcnt_q, stallcnt_d;

    always_comb begin
        ldcnt_d    = ldcnt_q;
        stcnt_d    = stcnt_q;
        stallcnt_d = stallcnt_q;
        if (state_q == BUSY && bus.dAck) begin
            if (we_q) stcnt_d = stcnt_q + 32'h1;
            else      ldcnt_d = ldcnt_q + 32'h1;
        end
        if (stall) stallcnt_d = stallcnt_q + 32'h1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ldcnt_q    <= 32'h0;
            stcnt_q    <= 32'h0;
            stallcnt_q <= 32'h0;
        end else begin
            ldcnt_q    <= ldcnt_d;
            stcnt_q    <= stcnt_d;
            stallcnt_q <= stallcnt_d;
        end
    end

    assign ldCnt    = ldcnt_q;
    assign stCnt    = stcnt_q;
    assign stallCnt = stallcnt_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short bus timeout (TIMEOUT_CYC=4).
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        memRdm;
    logic        memWrtm;
    logic [2:0]  funct3m;
    logic [31:0] aluRsltm;
    logic [31:0] wrtDatam;
    logic [31:0] readDm;
    logic        memStallm;
    logic        misAlgnm;
    logic        busErrm;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] ldCnt, stCnt, stallCnt;
`endif

    int total = 0;
    int bad   = 0;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT_CYC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .memRdm   (memRdm),
        .memWrtm  (memWrtm),
        .funct3m  (funct3m),
        .aluRsltm (aluRsltm),
        .wrtDatam (wrtDatam),
        .readDm   (readDm),
        .memStallm(memStallm),
        .misAlgnm (misAlgnm),
        .busErrm  (busErrm),
`ifdef MEM_PERF_CNT_EN
        .ldCnt    (ldCnt),
        .stCnt    (stCnt),
        .stallCnt (stallCnt),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        memRdm   = rd;
        memWrtm  = wr;
        funct3m  = f3;
        aluRsltm = addr;
        wrtDatam = wd;
    endtask

    // Issue one access; ack on BUSY cycle ack_at (0 = never). Returns what was seen on the bus.
    task automatic run_acc(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdata,
                           output int stall, output logic [31:0] a_o, output logic [31:0] wd_o,
                           output logic [3:0] be_o, output logic we_o, output int berr_at,
                           output logic hold_ok, output logic done_req, output logic [31:0] rdm);
        int n;
        @(negedge clk);
        set_in(rd, wr, f3, addr, wd);
        bus.dAck = 1'b0;
        stall    = 0;
        berr_at  = 0;
        hold_ok  = 1'b1;
        n        = 0;
        #1;
        a_o  = bus.dAddr;
        wd_o = bus.dWdata;
        be_o = bus.dBe;
        we_o = bus.dWe;
        if (memStallm) stall++;
        while (memStallm && stall < 20) begin
            @(negedge clk);
            n++;
            bus.dAck   = (n == ack_at);
            bus.dRdata = (n == ack_at) ? rdata : 32'h0;
            #1;
            if (memStallm) begin
                stall++;
                if (!bus.dReq || bus.dAddr !== a_o || bus.dWdata !== wd_o ||
                    bus.dBe !== be_o || bus.dWe !== we_o) hold_ok = 1'b0;
            end
            if (busErrm) berr_at = n;
        end
        bus.dAck = 1'b0;
        done_req = bus.dReq;
        rdm      = readDm;
    endtask

    task automatic bad_acc(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        set_in(rd, wr, f3, addr, 32'hFFFF_FFFF);
        #1;
        check({tag, "_misalgn"}, {31'h0, misAlgnm}, 32'h1);
        check({tag, "_dreq"},    {31'h0, bus.dReq}, 32'h0);
        check({tag, "_stall"},   {31'h0, memStallm}, 32'h0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check({tag, "_readdm"},  readDm, 32'h0);
        check({tag, "_pulse"},   {31'h0, misAlgnm}, 32'h0);
    endtask

    typedef struct {
        string       tag;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          ack_at;
        logic [31:0] rdata;
        int          exp_stall;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        logic        exp_we;
        int          exp_berr;
        logic [31:0] exp_rdm;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v);
        int          stall, berr_at;
        logic [31:0] a_o, wd_o, rdm;
        logic [3:0]  be_o;
        logic        we_o, hold_ok, done_req;
        run_acc(v.rd, v.wr, v.f3, v.addr, v.wd, v.ack_at, v.rdata,
                stall, a_o, wd_o, be_o, we_o, berr_at, hold_ok, done_req, rdm);
        check({v.tag, "_stall"}, stall, v.exp_stall);
        check({v.tag, "_addr"},  a_o, v.exp_addr);
        check({v.tag, "_be"},    {28'h0, be_o}, {28'h0, v.exp_be});
        check({v.tag, "_we"},    {31'h0, we_o}, {31'h0, v.exp_we});
        if (v.exp_we) check({v.tag, "_wdata"}, wd_o, v.exp_wd);
        check({v.tag, "_hold"},  {31'h0, hold_ok}, 32'h1);
        check({v.tag, "_berr"},  berr_at, v.exp_berr);
        check({v.tag, "_donereq"}, {31'h0, done_req}, 32'h0);
        check({v.tag, "_readdm"}, rdm, v.exp_rdm);
    endtask

    initial begin
        rst        = 1'b1;
        bus.dAck   = 1'b0;
        bus.dRdata = 32'h0;
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #2;
        check("rst_readdm", readDm, 32'h0);
        check("rst_stall",  {31'h0, memStallm}, 32'h0);
        check("rst_dreq",   {31'h0, bus.dReq}, 32'h0);
        check("rst_misalgn", {31'h0, misAlgnm}, 32'h0);
        check("rst_buserr", {31'h0, busErrm}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //            tag      rd wr f3      addr         wd            ack rdata         stl exp_addr     exp_wd        be       we berr exp_readDm
        vecs.push_back('{"lw",   1,0,3'b010,32'h100,32'h0,         1,32'hDEADBEEF,2,32'h100,32'h0,        4'b1111,0,0,32'hDEADBEEF});
        vecs.push_back('{"lb",   1,0,3'b000,32'h103,32'h0,         1,32'h80FFFF7F,2,32'h100,32'h0,        4'b1000,0,0,32'hFFFFFF80});
        vecs.push_back('{"lbu",  1,0,3'b100,32'h103,32'h0,         1,32'h80FFFF7F,2,32'h100,32'h0,        4'b1000,0,0,32'h00000080});
        vecs.push_back('{"lh",   1,0,3'b001,32'h102,32'h0,         1,32'h80FFFF7F,2,32'h100,32'h0,        4'b1100,0,0,32'hFFFF80FF});
        vecs.push_back('{"lhu",  1,0,3'b101,32'h102,32'h0,         1,32'h80FFFF7F,2,32'h100,32'h0,        4'b1100,0,0,32'h000080FF});
        vecs.push_back('{"sh",   0,1,3'b001,32'h202,32'h1234ABCD,  3,32'h0,       4,32'h200,32'hABCDABCD, 4'b1100,1,0,32'h000080FF});
        vecs.push_back('{"sb",   0,1,3'b000,32'h201,32'h123456EF,  1,32'h0,       2,32'h200,32'hEFEFEFEF, 4'b0010,1,0,32'h000080FF});
        vecs.push_back('{"rdwr", 1,1,3'b010,32'h400,32'h11223344,  1,32'h55555555,2,32'h400,32'h11223344, 4'b1111,1,0,32'h000080FF});
        foreach (vecs[i]) run_vec(vecs[i]);

        bad_acc("illf3", 1'b0, 1'b1, 3'b011, 32'h300);
        run_vec('{"lw2", 1,0,3'b010,32'h104,32'h0, 1,32'h5A5A5A5A,2,32'h104,32'h0,4'b1111,0,0,32'h5A5A5A5A});
        bad_acc("mislh", 1'b1, 1'b0, 3'b001, 32'h105);
        bad_acc("mislw", 1'b1, 1'b0, 3'b010, 32'h101);
        run_vec('{"lw3", 1,0,3'b010,32'h108,32'h0, 1,32'h0BADF00D,2,32'h108,32'h0,4'b1111,0,0,32'h0BADF00D});
        run_vec('{"tmo", 1,0,3'b010,32'h10C,32'h0, 0,32'h0,       5,32'h10C,32'h0,4'b1111,0,4,32'h0});
        run_vec('{"lw4", 1,0,3'b010,32'h110,32'h0, 1,32'hCAFEF00D,2,32'h110,32'h0,4'b1111,0,0,32'hCAFEF00D});

`ifdef MEM_PERF_CNT_EN
        check("perf_ld",    ldCnt, 32'd8);
        check("perf_st",    stCnt, 32'd3);
        check("perf_stall", stallCnt, 32'd29);
`endif

        // Reset during the second BUSY cycle, then a late ack that must be ignored.
        @(negedge clk);
        set_in(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        #1;
        check("rb_issue", {31'h0, bus.dReq}, 32'h1);
        @(negedge clk);
        #1;
        check("rb_busy1", {31'h0, memStallm}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rb_dreq",   {31'h0, bus.dReq}, 32'h0);
        check("rb_stall",  {31'h0, memStallm}, 32'h0);
        check("rb_readdm", readDm, 32'h0);
        check("rb_addr",   bus.dAddr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.dAck   = 1'b1;
        bus.dRdata = 32'h12345678;
        #1;
        check("rb_ack_stall", {31'h0, memStallm}, 32'h0);
        check("rb_ack_dreq",  {31'h0, bus.dReq}, 32'h0);
        @(negedge clk);
        bus.dAck = 1'b0;
        #1;
        check("rb_ack_readdm", readDm, 32'h0);
        check("rb_ack_idle",   {31'h0, memStallm}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
